detector_pulsaciones: RTL and testbench

- Sits directly downstream of the button debouncer.
- Consumes the debounced level and classifies each press as short or long.
- For a long press still held, emits periodic auto-repeat pulses.
- Outputs are single-cycle, registered strobes consumed by the control FSMs (e.g. menu or time-set logic).

---
 rtl/detector_pulsaciones.sv | 101 ++++++++++
 tb/tb_detector_pulsaciones.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_pulsaciones.sv
// Classifies debounced button presses as short or long and emits auto-repeat
// strobes while a long press is held. All strobes are registered and one-hot.
module detector_pulsaciones #(
    parameter int LARGO_CICLOS      = 8,
    parameter int REPETICION_CICLOS = 4,
    parameter int ANCHO_CONT        = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic dato_entrada,
    output logic presionado,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_repeticion
);

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        LARGO      = 2'd2
    } estado_t;

    localparam logic [ANCHO_CONT-1:0] LARGO_FIN = ANCHO_CONT'(LARGO_CICLOS - 1);
    localparam logic [ANCHO_CONT-1:0] REP_FIN   = ANCHO_CONT'(REPETICION_CICLOS - 1);
    localparam logic [ANCHO_CONT-1:0] UNO       = ANCHO_CONT'(1);
    localparam logic [ANCHO_CONT-1:0] CERO      = '0;

    estado_t               estado, estado_sig;
    logic [ANCHO_CONT-1:0] cont, cont_sig;
    logic                  entrada_r;
    logic                  corto_sig, largo_sig, repeticion_sig;

    assign presionado = entrada_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado           <= REPOSO;
            cont             <= CERO;
            entrada_r        <= 1'b0;
            pulso_corto      <= 1'b0;
            pulso_largo      <= 1'b0;
            pulso_repeticion <= 1'b0;
        end else begin
            estado           <= estado_sig;
            cont             <= cont_sig;
            entrada_r        <= dato_entrada;
            pulso_corto      <= corto_sig;
            pulso_largo      <= largo_sig;
            pulso_repeticion <= repeticion_sig;
        end
    end

    always_comb begin
        estado_sig     = estado;
        cont_sig       = cont;
        corto_sig      = 1'b0;
        largo_sig      = 1'b0;
        repeticion_sig = 1'b0;
        case (estado)
            REPOSO: begin
                if (entrada_r) begin
                    estado_sig = PRESIONADO;
                    cont_sig   = UNO;
                end else begin
                    cont_sig   = CERO;
                end
            end
            PRESIONADO: begin
                if (!entrada_r) begin
                    corto_sig  = 1'b1;
                    estado_sig = REPOSO;
                    cont_sig   = CERO;
                end else if (cont == LARGO_FIN) begin
                    // Repeat period is measured from the long strobe itself,
                    // so the first repeat lands REPETICION_CICLOS after it.
                    largo_sig  = 1'b1;
                    estado_sig = LARGO;
                    cont_sig   = CERO;
                end else begin
                    cont_sig   = cont + UNO;
                end
            end
            LARGO: begin
                if (!entrada_r) begin
                    estado_sig = REPOSO;
                    cont_sig   = CERO;
                end else if (cont == REP_FIN) begin
                    repeticion_sig = 1'b1;
                    cont_sig       = CERO;
                end else begin
                    cont_sig       = cont + UNO;
                end
            end
            default: begin
                estado_sig = REPOSO;
                cont_sig   = CERO;
            end
        endcase
    end

endmodule

// File: tb/tb_detector_pulsaciones.sv
// Bench for detector_pulsaciones: directed press scenarios plus random presses,
// checked against a run-length model of the sampled button level.
module tb_detector_pulsaciones;

    localparam int L = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset;
    logic dato_entrada;
    logic presionado, pulso_corto, pulso_largo, pulso_repeticion;

    int total = 0;
    int bad   = 0;

    // Run length of consecutive 1 samples after the previous edge and the one before.
    int r1 = 0;
    int r2 = 0;

    // Per edge: {presionado, pulso_corto, pulso_largo, pulso_repeticion}
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    always #5 clk = ~clk;

    detector_pulsaciones #(
        .LARGO_CICLOS(L),
        .REPETICION_CICLOS(R),
        .ANCHO_CONT(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dato_entrada(dato_entrada),
        .presionado(presionado),
        .pulso_corto(pulso_corto),
        .pulso_largo(pulso_largo),
        .pulso_repeticion(pulso_repeticion)
    );

    function automatic logic [3:0] observed();
        return {presionado, pulso_corto, pulso_largo, pulso_repeticion};
    endfunction

    // One clock: drive d, let the edge sample it, record DUT and model outputs.
    task automatic apply(input logic d);
        logic [3:0] e;
        dato_entrada = d;
        @(posedge clk);
        #1;
        e[3] = d;
        e[2] = (r1 == 0) && (r2 >= 1) && (r2 < L);
        e[1] = (r1 == L);
        e[0] = (r1 > L) && (((r1 - L) % R) == 0);
        exp_q.push_back(e);
        obs_q.push_back(observed());
        r2 = r1;
        r1 = d ? r1 + 1 : 0;
    endtask

    task automatic drive_press(input int k, input int tail);
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < k + tail; i++) apply(i < k);
    endtask

    function automatic int nth_edge(input int b, input int n);
        int seen = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i][b]) begin
                seen++;
                if (seen == n) return i + 1;
            end
        end
        return 0;
    endfunction

    function automatic int count_bit(input int b);
        int c = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][b]) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        dato_entrada = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (observed() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_init: got %b want 0000", observed());
        end
        reset = 1'b0;
        r1 = 0;
        r2 = 0;
        drive_press(5, 0);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (observed() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async: got %b want 0000", observed());
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r1 = 0;
        r2 = 0;
        drive_press(12, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_restart edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(1, 1) != 9 || count_bit(2) != 0) begin
            bad++;
            $display("FAIL reset_largo_edge: got largo@%0d cortos=%0d want largo@9 cortos=0",
                     nth_edge(1, 1), count_bit(2));
        end
    endtask

    task automatic test_short();
        drive_press(3, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL short_k3 edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(2, 1) != 5 || count_bit(2) != 1 || count_bit(3) != 3 ||
            count_bit(1) != 0 || count_bit(0) != 0) begin
            bad++;
            $display("FAIL short_k3_edges: got corto@%0d n=%0d pres=%0d want corto@5 n=1 pres=3",
                     nth_edge(2, 1), count_bit(2), count_bit(3));
        end
    endtask

    task automatic test_threshold();
        drive_press(7, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL thr_k7 edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(2, 1) != 9 || count_bit(1) != 0) begin
            bad++;
            $display("FAIL thr_k7_edges: got corto@%0d largos=%0d want corto@9 largos=0",
                     nth_edge(2, 1), count_bit(1));
        end
        drive_press(8, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL thr_k8 edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(1, 1) != 9 || count_bit(2) != 0 || count_bit(0) != 0) begin
            bad++;
            $display("FAIL thr_k8_edges: got largo@%0d cortos=%0d want largo@9 cortos=0",
                     nth_edge(1, 1), count_bit(2));
        end
    endtask

    task automatic test_hold();
        drive_press(20, 8);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hold20 edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(1, 1) != 9 || nth_edge(0, 1) != 13 || nth_edge(0, 2) != 17 ||
            nth_edge(0, 3) != 21 || count_bit(0) != 3 || count_bit(2) != 0) begin
            bad++;
            $display("FAIL hold20_edges: got largo@%0d rep@%0d,%0d,%0d nrep=%0d want 9 13,17,21 3",
                     nth_edge(1, 1), nth_edge(0, 1), nth_edge(0, 2), nth_edge(0, 3), count_bit(0));
        end
        drive_press(11, 8);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hold11 edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (nth_edge(1, 1) != 9 || count_bit(0) != 0 || count_bit(2) != 0) begin
            bad++;
            $display("FAIL hold11_edges: got largo@%0d reps=%0d cortos=%0d want 9 0 0",
                     nth_edge(1, 1), count_bit(0), count_bit(2));
        end
    endtask

    task automatic test_back_to_back();
        logic pat [9];
        int consecutive = 0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 9; i++) apply(pat[i]);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
            if (i > 0 && (obs_q[i][2:0] & obs_q[i-1][2:0]) != 3'b000) consecutive++;
        end
        total++;
        if (count_bit(2) != 3 || consecutive != 0 || nth_edge(2, 1) != 3 ||
            nth_edge(2, 2) != 5 || nth_edge(2, 3) != 7) begin
            bad++;
            $display("FAIL b2b_cortos: got n=%0d @%0d,%0d,%0d consecutive=%0d want 3 @3,5,7 0",
                     count_bit(2), nth_edge(2, 1), nth_edge(2, 2), nth_edge(2, 3), consecutive);
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        obs_q.delete();
        for (int p = 0; p < 20; p++) begin
            int k;
            int gap;
            k   = $urandom_range(1, 24);
            gap = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) apply(1'b1);
            for (int i = 0; i < gap; i++) apply(1'b0);
        end
        for (int i = 0; i < 4; i++) apply(1'b0);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random edge %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
            total++;
            if ($countones(obs_q[i][2:0]) > 1) begin
                bad++;
                $display("FAIL random_onehot edge %0d: got %b want at most one strobe",
                         i + 1, obs_q[i][2:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        dato_entrada = 1'b0;
        test_reset();
        test_short();
        test_threshold();
        test_hold();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
